// File: rtl/axi_defs_pkg.sv
// Shared AXI command types, scheduler state encoding and the legal WRAP
// lengths used by the command scheduler and its burst checker.
package axi_defs_pkg;

    typedef enum logic [0:0] {
        AXI_READ  = 1'b0,
        AXI_WRITE = 1'b1
    } axi_op_t;

    typedef enum logic [1:0] {
        FIXED    = 2'd0,
        INCR     = 2'd1,
        WRAP     = 2'd2,
        RESERVED = 2'd3
    } axi_burst_t;

    typedef enum logic [1:0] {
        NO_ERROR       = 2'd0,
        TIMEOUT_ERROR  = 2'd1,
        CHECKSUM_ERROR = 2'd2,
        PROTOCOL_ERROR = 2'd3
    } error_type_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } sched_state_e;

    // WRAP bursts must be 2, 4, 8 or 16 beats (len is beats-1).
    localparam int                  WRAP_LEN_NUM = 4;
    localparam logic [3:0][7:0]     WRAP_LENS    = {8'd15, 8'd7, 8'd3, 8'd1};

    function automatic logic wrap_len_ok(input logic [7:0] len);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < WRAP_LEN_NUM; i++) begin
            if (len == WRAP_LENS[i]) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/axi_burst_checker.sv
// Combinational burst legality check: rejects RESERVED bursts and WRAP
// bursts whose length is not a supported power of two.
module axi_burst_checker
    import axi_defs_pkg::*;
(
    input  logic [1:0] burst_i,
    input  logic [7:0] len_i,
    output logic       legal_o
);

    always_comb begin
        legal_o = 1'b1;
        if (burst_i == RESERVED) begin
            legal_o = 1'b0;
        end else if (burst_i == WRAP && !wrap_len_ok(len_i)) begin
            legal_o = 1'b0;
        end
    end

endmodule

// File: rtl/axi_cmd_scheduler.sv
// Round-robin read/write command scheduler with one outstanding AXI
// transaction, burst legality check and response timeout.
module axi_cmd_scheduler
    import axi_defs_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 256
)(
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [7:0]        rd_req_len,
    input  logic [1:0]        rd_req_burst,

    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [7:0]        wr_req_len,
    input  logic [1:0]        wr_req_burst,

    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    output logic [1:0]        cmd_burst,

    input  logic              rsp_valid,
    input  logic              rsp_err,

    output logic              done_valid,
    output logic              done_op,
    output logic [1:0]        done_err,
    output logic              busy
);

    localparam int               CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    sched_state_e      state_q, state_d;
    axi_op_t           last_grant_q, last_grant_d;
    axi_op_t           op_q, op_d;
    error_type_e       err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [1:0]        burst_q, burst_d;

    logic              rd_win, wr_win;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_len;
    logic [1:0]        sel_burst;
    logic              sel_legal;

    // On a tie the op opposite to the previous grant wins.
    assign rd_win = rd_req_valid && (!wr_req_valid || last_grant_q == AXI_WRITE);
    assign wr_win = wr_req_valid && !rd_win;

    assign sel_addr  = rd_win ? rd_req_addr  : wr_req_addr;
    assign sel_len   = rd_win ? rd_req_len   : wr_req_len;
    assign sel_burst = rd_win ? rd_req_burst : wr_req_burst;

    axi_burst_checker u_burst_checker (
        .burst_i (sel_burst),
        .len_i   (sel_len),
        .legal_o (sel_legal)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        len_d        = len_q;
        burst_d      = burst_q;
        rd_req_ready = 1'b0;
        wr_req_ready = 1'b0;

        case (state_q)
            IDLE: begin
                rd_req_ready = rd_win;
                wr_req_ready = wr_win;
                if (rd_win || wr_win) begin
                    op_d         = rd_win ? AXI_READ : AXI_WRITE;
                    last_grant_d = op_d;
                    addr_d       = sel_addr;
                    len_d        = sel_len;
                    burst_d      = sel_burst;
                    if (sel_legal) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                        err_d   = PROTOCOL_ERROR;
                    end
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_d = WAIT_RSP;
                    cnt_d   = '0;
                end
            end
            WAIT_RSP: begin
                // A response on the final timeout cycle takes precedence.
                if (rsp_valid) begin
                    state_d = DONE;
                    err_d   = rsp_err ? PROTOCOL_ERROR : NO_ERROR;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = DONE;
                    err_d   = TIMEOUT_ERROR;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            last_grant_q <= AXI_WRITE;
            op_q         <= AXI_READ;
            err_q        <= NO_ERROR;
            cnt_q        <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            burst_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            burst_q      <= burst_d;
        end
    end

    assign cmd_valid  = (state_q == ISSUE);
    assign cmd_op     = op_q;
    assign cmd_addr   = addr_q;
    assign cmd_len    = len_q;
    assign cmd_burst  = burst_q;
    assign done_valid = (state_q == DONE);
    assign done_op    = done_valid ? op_q : AXI_READ;
    assign done_err   = done_valid ? err_q : NO_ERROR;
    assign busy       = (state_q != IDLE);

endmodule
